// File: rtl/sequential_multiplier.sv
// sequential_multiplier: iterative radix-2 shift-add multiplier with
// valid/ready handshakes on both sides. Handles unsigned or two's-complement
// operands, chosen per operation. One result every width + 2 cycles.
//
// Optional feature, enabled by defining MULTIPLIER_ACCUMULATE_EN:
//   adds an 'accumulate' input and a 2*width accumulator register. When
//   accumulate is set at accept, the previous result is added to the new
//   product (mod 2^(2*width)). The low half of the accumulator is preloaded
//   into the partial sum, and the high half is added on the final iteration,
//   so latency does not change.
module sequential_multiplier #(
   parameter int width = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 input_valid,
   output logic                 input_ready,
   input  logic [width-1:0]     input0,
   input  logic [width-1:0]     input1,
   input  logic                 signed_mode,
`ifdef MULTIPLIER_ACCUMULATE_EN
   input  logic                 accumulate,
`endif
   output logic                 output_valid,
   input  logic                 output_ready,
   output logic [2*width-1:0]   product
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [width-1:0]     mcand_q, mcand_d;
   // Upper half: running partial sum. Lower half: remaining multiplier bits,
   // which are replaced by finished product bits as the register shifts.
   logic [2*width-1:0]   prod_q, prod_d;
   logic                 signed_q, signed_d;

`ifdef MULTIPLIER_ACCUMULATE_EN
   logic [2*width-1:0]   acc_q, acc_d;
   logic                 accum_q, accum_d;
   logic [width-1:0]     hi_fix;
`endif

   logic                 last_iter;
   logic [width:0]       hi_ext;
   logic [width:0]       mc_ext;
   logic [width:0]       addend;
   logic [width:0]       sum;
   logic [2*width-1:0]   shifted;
   logic [width-1:0]     preload;

   // Datapath: one (width+1)-bit add or subtract, then shift right by one.
   always_comb begin
      last_iter = (count_q == CW'(width - 1));
      // Extension of the partial sum and multiplicand selects the kind of shift:
      // sign bit in signed mode (arithmetic), zero in unsigned mode (the adder
      // carry becomes the top bit, i.e. logical shift of the full sum).
      hi_ext    = {signed_q & prod_q[2*width-1], prod_q[2*width-1:width]};
      mc_ext    = {signed_q & mcand_q[width-1], mcand_q};
      addend    = prod_q[0] ? mc_ext : '0;
      // The multiplier's sign bit carries negative weight in signed mode.
      if (last_iter && signed_q) begin
         sum = hi_ext - addend;
      end else begin
         sum = hi_ext + addend;
      end
      shifted   = {sum, prod_q[width-1:1]};
   end

`ifdef MULTIPLIER_ACCUMULATE_EN
   // Accumulator folding: the low half rides in the initial partial sum (read
   // as signed in signed mode, so its sign bit is returned as a carry into the
   // high half); the high half is added on the last iteration.
   always_comb begin
      preload = '0;
      hi_fix  = '0;
      if (accumulate) begin
         preload = acc_q[width-1:0];
      end
      if (accum_q) begin
         hi_fix = acc_q[2*width-1:width]
                + {{(width-1){1'b0}}, signed_q & acc_q[width-1]};
      end
   end
`else
   // Pure multiply: partial sum starts at zero.
   always_comb begin
      preload = '0;
   end
`endif

   // Next-state, datapath load and handshake outputs.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      mcand_d      = mcand_q;
      prod_d       = prod_q;
      signed_d     = signed_q;
      input_ready  = 1'b0;
      output_valid = 1'b0;
`ifdef MULTIPLIER_ACCUMULATE_EN
      acc_d        = acc_q;
      accum_d      = accum_q;
`endif
      case (state_q)
         IDLE: begin
            input_ready = 1'b1;
            if (input_valid) begin
               mcand_d  = input0;
               prod_d   = {preload, input1};
               signed_d = signed_mode;
               count_d  = '0;
`ifdef MULTIPLIER_ACCUMULATE_EN
               accum_d  = accumulate;
`endif
               state_d  = COMPUTE;
            end
         end
         COMPUTE: begin
            prod_d  = shifted;
            count_d = count_q + CW'(1);
            if (last_iter) begin
`ifdef MULTIPLIER_ACCUMULATE_EN
               prod_d = {shifted[2*width-1:width] + hi_fix, shifted[width-1:0]};
`endif
               count_d = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            output_valid = 1'b1;
            if (output_ready) begin
`ifdef MULTIPLIER_ACCUMULATE_EN
               acc_d   = prod_q;
`endif
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset discards any in-flight operation immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         signed_q <= 1'b0;
`ifdef MULTIPLIER_ACCUMULATE_EN
         acc_q    <= '0;
         accum_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         signed_q <= signed_d;
`ifdef MULTIPLIER_ACCUMULATE_EN
         acc_q    <= acc_d;
         accum_q  <= accum_d;
`endif
      end
   end

   assign product = prod_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Bench for sequential_multiplier: width-8 and width-16 instances, directed
// vectors with hand-computed products. Drivers push expected products into
// queues; monitors pop and compare at every output handshake.
module tb_sequential_multiplier;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // width = 8 instance
   logic        iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b1;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] p8;
`ifdef MULTIPLIER_ACCUMULATE_EN
   logic        acc8 = 1'b0;
`endif

   // width = 16 instance
   logic        iv16 = 1'b0, ir16, s16 = 1'b0, ov16, or16 = 1'b1;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] p16;
`ifdef MULTIPLIER_ACCUMULATE_EN
   logic        acc16 = 1'b0;
`endif

   sequential_multiplier #(.width(8)) dut8 (
      .clock(clock), .reset_n(reset_n),
      .input_valid(iv8), .input_ready(ir8),
      .input0(a8), .input1(b8), .signed_mode(s8),
`ifdef MULTIPLIER_ACCUMULATE_EN
      .accumulate(acc8),
`endif
      .output_valid(ov8), .output_ready(or8), .product(p8)
   );

   sequential_multiplier #(.width(16)) dut16 (
      .clock(clock), .reset_n(reset_n),
      .input_valid(iv16), .input_ready(ir16),
      .input0(a16), .input1(b16), .signed_mode(s16),
`ifdef MULTIPLIER_ACCUMULATE_EN
      .accumulate(acc16),
`endif
      .output_valid(ov16), .output_ready(or16), .product(p16)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] q8[$];
   logic [31:0] q16[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: compare each delivered product with the oldest expectation.
   always @(negedge clock) begin
      if (reset_n && ov8 && or8) begin
         if (q8.size() == 0) begin
            check("dut8 unexpected output", 64'(p8), 64'hDEAD_BEEF);
         end else begin
            logic [15:0] e;
            e = q8.pop_front();
            $display("txn w8  product=0x%04h expected=0x%04h", p8, e);
            check("dut8 product", 64'(p8), 64'(e));
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n && ov16 && or16) begin
         if (q16.size() == 0) begin
            check("dut16 unexpected output", 64'(p16), 64'hDEAD_BEEF);
         end else begin
            logic [31:0] e;
            e = q16.pop_front();
            $display("txn w16 product=0x%08h expected=0x%08h", p16, e);
            check("dut16 product", 64'(p16), 64'(e));
         end
      end
   end

   // Wait (bounded) for input_ready, present operands for one accept cycle.
   task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic acc);
      int n;
      n = 0;
      @(negedge clock);
      while (!ir8 && n < 60) begin
         @(negedge clock);
         n++;
      end
      check("dut8 input_ready before accept", 64'(ir8), 64'd1);
      a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
`ifdef MULTIPLIER_ACCUMULATE_EN
      acc8 = acc;
`else
      if (acc) $display("note: accumulate request ignored in this build");
`endif
      @(posedge clock);
      #1 iv8 = 1'b0;
   endtask

   // Full width-8 operation: latency check, optional backpressure hold and
   // operand scrambling during COMPUTE.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic acc,
                      input logic [15:0] exp, input int hold, input logic scramble);
      int cyc;
      or8 = (hold == 0);
      accept8(a, b, s, acc);
      q8.push_back(exp);
      cyc = 0;
      while (cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (ov8) break;
         if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
         end
      end
      check("dut8 latency", 64'(cyc), 64'd9);
      if (hold > 0) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            #1 iv8 = 1'b1;
            @(negedge clock);
            check("hold product", 64'(p8), 64'(exp));
            check("hold input_ready", 64'(ir8), 64'd0);
            check("hold output_valid", 64'(ov8), 64'd1);
         end
         @(posedge clock);
         #1 or8 = 1'b1;
         @(negedge clock);
      end
      @(posedge clock);
      #1 iv8 = 1'b0;
      @(negedge clock);
      check("dut8 output_valid after handshake", 64'(ov8), 64'd0);
      check("dut8 input_ready after handshake", 64'(ir8), 64'd1);
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] exp);
      int cyc;
      int n;
      n = 0;
      @(negedge clock);
      while (!ir16 && n < 60) begin
         @(negedge clock);
         n++;
      end
      a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
      @(posedge clock);
      #1 iv16 = 1'b0;
      q16.push_back(exp);
      cyc = 0;
      while (cyc < 60) begin
         @(negedge clock);
         cyc++;
         if (ov16) break;
      end
      check("dut16 latency", 64'(cyc), 64'd17);
      @(negedge clock);
      check("dut16 input_ready after handshake", 64'(ir16), 64'd1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      #12;
      check("reset input_ready", 64'(ir8), 64'd1);
      check("reset output_valid", 64'(ov8), 64'd0);
      check("reset product", 64'(p8), 64'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Basic unsigned and signed vectors
      op8(8'd3,   8'd5,   1'b0, 1'b0, 16'h000F, 0, 1'b0);
      op8(8'hFF,  8'hFF,  1'b0, 1'b0, 16'hFE01, 0, 1'b0);
      op8(8'h80,  8'h80,  1'b1, 1'b0, 16'h4000, 0, 1'b0);
      op8(8'hFF,  8'h01,  1'b1, 1'b0, 16'hFFFF, 0, 1'b0);
      op8(8'h7F,  8'h80,  1'b1, 1'b0, 16'hC080, 0, 1'b0);
      op8(8'h80,  8'h7F,  1'b1, 1'b0, 16'hC080, 0, 1'b0);
      op8(8'hFF,  8'hFF,  1'b1, 1'b0, 16'h0001, 0, 1'b0);
      op8(8'h00,  8'hA5,  1'b0, 1'b0, 16'h0000, 0, 1'b0);

      // Backpressure: 12 x 13 = 156, consumer stalls 20 cycles
      op8(8'd12,  8'd13,  1'b0, 1'b0, 16'h009C, 20, 1'b0);

      // Operands scrambled during COMPUTE: -5 x 6 = -30
      op8(8'hFB,  8'h06,  1'b1, 1'b0, 16'hFFE2, 0, 1'b1);

      // Reset on cycle 4 of COMPUTE discards the operation
      or8 = 1'b1;
      accept8(8'd9, 8'd9, 1'b0, 1'b0);
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("async reset output_valid", 64'(ov8), 64'd0);
      check("async reset input_ready", 64'(ir8), 64'd1);
      check("async reset product", 64'(p8), 64'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      op8(8'd6,   8'd7,   1'b0, 1'b0, 16'h002A, 0, 1'b0);

`ifdef MULTIPLIER_ACCUMULATE_EN
      op8(8'd10,  8'd10,  1'b0, 1'b0, 16'h0064, 0, 1'b0);
      op8(8'd3,   8'd4,   1'b0, 1'b1, 16'h0070, 0, 1'b0);
      op8(8'hFF,  8'hFF,  1'b0, 1'b1, 16'hFE71, 0, 1'b0);
      // Signed accumulate: 0xFE71 + (-2 x 3) = 0xFE6B
      op8(8'hFE,  8'h03,  1'b1, 1'b1, 16'hFE6B, 0, 1'b0);
      op8(8'd2,   8'd2,   1'b0, 1'b0, 16'h0004, 0, 1'b0);
`endif

      // Width 16
      op16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
      op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
      op16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE);

      n = 0;
      while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("dut8 scoreboard drained", 64'(q8.size()), 64'd0);
      check("dut16 scoreboard drained", 64'(q16.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sequential_multiplier.md
# sequential_multiplier

Iterative radix-2 shift-add multiplier: a parametrised, handshaked successor to the combinational array multiplier. It trades area for latency, needing one adder of `width + 1` bits instead of `width - 1`. It supports unsigned and two's-complement signed operands, selected per operation. It sits between a producer and a consumer that both use valid/ready handshakes, and serves datapaths where a full array multiplier is too large.

## Interface
Parameters:
- `width`, default 8: operand width in bits; legal range 2 to 64; product is `2 * width` bits.

Ports:
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: reset, asynchronous, active-low.
- `input_valid`  input  1: operands presented.
- `input_ready`  output  1: block can accept operands.
- `input0`  input  `width`: multiplicand.
- `input1`  input  `width`: multiplier.
- `signed_mode`  input  1: 1 means both operands are two's complement; 0 means both are unsigned.
- `output_valid`  output  1: `product` is valid.
- `output_ready`  input  1: consumer takes `product`.
- `product`  output  `2 * width`: exact result.
- `accumulate`  input  1: present only with `MULTIPLIER_ACCUMULATE_EN` (see Configuration).

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - `input_ready` = 1.
  - On `input_valid & input_ready`: capture `input0`, `input1`, `signed_mode` (and `accumulate`), clear the partial sum and iteration counter, then go to COMPUTE.
- COMPUTE, iteration i from 0 to `width - 1`:
  - If multiplier bit i = 1, add the multiplicand, sign-extended to `width + 1` bits in signed mode and zero-extended in unsigned mode, into the upper half of the partial sum.
  - In signed mode, at i = `width - 1`, subtract instead of add (sign-bit weight is negative).
  - Shift right by one, arithmetic in signed mode and logical in unsigned mode.
  - After iteration `width - 1`, go to DONE.
- DONE:
  - `output_valid` = 1 and `product` is held stable.
  - On `output_ready`, go to IDLE.
- Arithmetic rules:
  - `product` equals the mathematically exact result in `2 * width` bits; no overflow is possible.
  - Signed: the most negative × most negative result is positive and correct.
- Operand inputs are ignored outside the IDLE accept cycle. Changing them during COMPUTE has no effect.
- `input_valid` deasserting before acceptance is legal; nothing is captured.

## Timing
- Reset values: `input_ready` = 1, `output_valid` = 0, `product` = 0, state IDLE, counter 0, accumulator register 0.
- Assertion of `reset_n` low takes effect immediately, whatever the state. An in-flight operation is discarded with no output. Deassertion is synchronised by the integrator.
- Latency: accept on cycle 0 → COMPUTE on cycles 1 to `width` → `output_valid` high from cycle `width + 1`.
- Backpressure: `output_valid` and `product` are held for any number of cycles until `output_ready`. `input_ready` stays 0 meanwhile.
- Completing the output handshake on cycle n puts `input_ready` = 1 on cycle n + 1; inputs cannot be accepted in the same cycle.
- Maximum throughput: one result every `width + 2` cycles.
- `output_ready` asserted while `output_valid` = 0 has no effect.

## Configuration
- With `MULTIPLIER_ACCUMULATE_EN` defined:
  - The `accumulate` port exists and an internal `2 * width` accumulator register is kept.
  - If `accumulate` = 1 at accept: `product` = previous accumulator + new product, wrapping modulo 2^(2·`width`).
  - If `accumulate` = 0: `product` = new product.
  - The accumulator is loaded with each `product` at the DONE→IDLE handshake.
  - Latency is unchanged; the add is folded into the initial partial sum.
- Without the macro: no `accumulate` port, no accumulator register, pure multiply.

## Test plan
- `width` = 8, unsigned, 3 × 5 accepted on cycle 0, `output_ready` tied 1 → `product` = 0x000F with `output_valid` on cycle 9 only; `input_ready` back on cycle 10.
- Unsigned 255 × 255 → 0xFE01. Signed 0x80 × 0x80 → 0x4000. Signed 0xFF × 0x01 → 0xFFFF. Signed 0x7F × 0x80 → 0xC080.
- Result ready with `output_ready` held 0 for 20 cycles → `product` stable and `input_ready` = 0 throughout. A new `input_valid` is not accepted until the cycle after `output_ready`.
- `reset_n` pulsed low on cycle 4 of COMPUTE → `output_valid` = 0 and `input_ready` = 1 immediately. The next operation (6 × 7 = 0x002A) completes correctly.
- Operands changed every cycle during COMPUTE → result reflects only the captured values. `width` = 16 signed 0x8000 × 0x8000 → 0x40000000 after 17 cycles.
- With `MULTIPLIER_ACCUMULATE_EN`, unsigned: 10 × 10 with accumulate = 0 → 0x0064. Then 3 × 4 with accumulate = 1 → 0x0070. Then 255 × 255 with accumulate = 1 → 0xFE71.
